// File: rtl/chunked_adder_seq.sv
// Multi-cycle add/subtract unit: WIDTH-bit operands are summed CHUNK bits per clock
// through a registered carry chain, behind valid/ready handshakes on both sides.
module chunked_adder_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] num_1,
   input  logic [WIDTH-1:0] num_2,
   input  logic             c,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow,
   output logic             busy
);

   localparam int N     = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   generate
      if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
         $error("chunked_adder_seq: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state_r;
   state_t           state_n;
   logic [IDX_W-1:0] idx_r;
   logic [IDX_W-1:0] idx_n;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] a_n;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] b_n;
   logic [WIDTH-1:0] sum_r;
   logic [WIDTH-1:0] sum_n;
   logic             cy_r;
   logic             cy_n;
   logic             carry_r;
   logic             carry_n;
   logic             overflow_r;
   logic             overflow_n;
   logic             out_valid_r;
   logic             in_ready_r;
   logic             busy_r;

   logic [CHUNK-1:0] a_chunk_s;
   logic [CHUNK-1:0] b_chunk_s;
   logic [CHUNK-1:0] chunk_sum_s;
   logic             chunk_co_s;
   logic             msb_cin_s;
   logic             last_s;

   // One chunk of the ripple: returns {carry_out, sum}.
   function automatic logic [CHUNK:0] add_chunk(
      input logic [CHUNK-1:0] x,
      input logic [CHUNK-1:0] y,
      input logic             cin
   );
      add_chunk = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
   endfunction

   // Current-chunk datapath; carry into the MSB is recovered from the MSB sum bit.
   always_comb begin
      a_chunk_s                 = a_r[idx_r*CHUNK +: CHUNK];
      b_chunk_s                 = b_r[idx_r*CHUNK +: CHUNK];
      {chunk_co_s, chunk_sum_s} = add_chunk(a_chunk_s, b_chunk_s, cy_r);
      msb_cin_s                 = chunk_sum_s[CHUNK-1] ^ a_chunk_s[CHUNK-1] ^ b_chunk_s[CHUNK-1];
      last_s                    = (idx_r == IDX_W'(N - 1));
   end

   // Next-state and next-datapath logic.
   always_comb begin
      state_n    = state_r;
      idx_n      = idx_r;
      a_n        = a_r;
      b_n        = b_r;
      sum_n      = sum_r;
      cy_n       = cy_r;
      carry_n    = carry_r;
      overflow_n = overflow_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_n = RUN;
               idx_n   = {IDX_W{1'b0}};
               a_n     = num_1;
               b_n     = sub ? ~num_2 : num_2;
               cy_n    = sub ^ c;
            end else begin
               state_n = IDLE;
            end
         end
         RUN: begin
            sum_n[idx_r*CHUNK +: CHUNK] = chunk_sum_s;
            cy_n                        = chunk_co_s;
            if (last_s) begin
               state_n    = DONE;
               idx_n      = {IDX_W{1'b0}};
               carry_n    = chunk_co_s;
               overflow_n = msb_cin_s ^ chunk_co_s;
            end else begin
               state_n = RUN;
               idx_n   = idx_r + IDX_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_n = IDLE;
            end else begin
               state_n = DONE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State, datapath and handshake registers; flags are decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         idx_r       <= {IDX_W{1'b0}};
         a_r         <= {WIDTH{1'b0}};
         b_r         <= {WIDTH{1'b0}};
         sum_r       <= {WIDTH{1'b0}};
         cy_r        <= 1'b0;
         carry_r     <= 1'b0;
         overflow_r  <= 1'b0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_n;
         idx_r       <= idx_n;
         a_r         <= a_n;
         b_r         <= b_n;
         sum_r       <= sum_n;
         cy_r        <= cy_n;
         carry_r     <= carry_n;
         overflow_r  <= overflow_n;
         out_valid_r <= (state_n == DONE);
         in_ready_r  <= (state_n == IDLE);
         busy_r      <= (state_n != IDLE);
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign sum       = sum_r;
   assign carry     = carry_r;
   assign overflow  = overflow_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Self-checking bench for chunked_adder_seq: a W16/C4 and a W16/C16 instance driven
// with directed and random operations, compared against an integer arithmetic model.
module tb_chunked_adder_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid_a, in_valid_b, out_ready_a, out_ready_b;
   logic [15:0] num_1, num_2;
   logic        c_in, sub_in;
   logic        in_ready_a, out_valid_a, carry_a, overflow_a, busy_a;
   logic        in_ready_b, out_valid_b, carry_b, overflow_b, busy_b;
   logic [15:0] sum_a, sum_b;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   chunked_adder_seq #(.WIDTH(16), .CHUNK(4)) dut_c4 (
      .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .num_1(num_1), .num_2(num_2), .c(c_in), .sub(sub_in),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .sum(sum_a),
      .carry(carry_a), .overflow(overflow_a), .busy(busy_a)
   );

   chunked_adder_seq #(.WIDTH(16), .CHUNK(16)) dut_c16 (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .num_1(num_1), .num_2(num_2), .c(c_in), .sub(sub_in),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .sum(sum_b),
      .carry(carry_b), .overflow(overflow_b), .busy(busy_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Plain integer arithmetic: unsigned result for sum/carry, signed result for overflow.
   function automatic void ref_op(input int w, input longint a, input longint b,
                                  input bit c, input bit sb,
                                  output longint s, output bit cy, output bit ov);
      longint m, r, sa, sbv, sr;
      m   = longint'(1) << w;
      r   = sb ? (a - b - longint'(c)) : (a + b + longint'(c));
      s   = ((r % m) + m) % m;
      cy  = sb ? (r >= 0) : (r >= m);
      sa  = (a >= m / 2) ? a - m : a;
      sbv = (b >= m / 2) ? b - m : b;
      sr  = sb ? (sa - sbv - longint'(c)) : (sa + sbv + longint'(c));
      ov  = (sr < -(m / 2)) || (sr >= m / 2);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_inputs;
      num_1  = 16'($urandom);
      num_2  = 16'($urandom);
      c_in   = 1'($urandom);
      sub_in = 1'($urandom);
   endtask

   task automatic run_op(input bit sel, input logic [15:0] a, input logic [15:0] b,
                         input bit c, input bit sb, input int hold);
      longint es;
      bit     ec, eo;
      int     n_exp, cnt;
      n_exp = sel ? 1 : 4;
      ref_op(16, longint'(a), longint'(b), c, sb, es, ec, eo);
      num_1 = a; num_2 = b; c_in = c; sub_in = sb;
      if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
      tick;
      in_valid_a = 1'b0; in_valid_b = 1'b0;
      scramble_inputs();
      check_eq("in_ready_run", 32'(sel ? in_ready_b : in_ready_a), 0);
      check_eq("busy_run", 32'(sel ? busy_b : busy_a), 1);
      cnt = 0;
      while (cnt < 20 && !(sel ? out_valid_b : out_valid_a)) begin
         tick;
         cnt++;
      end
      check_eq("latency", cnt, n_exp);
      for (int i = 0; i < hold; i++) begin
         if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
         scramble_inputs();
         tick;
         check_eq("hold_valid", 32'(sel ? out_valid_b : out_valid_a), 1);
         check_eq("hold_sum", 32'(sel ? sum_b : sum_a), 32'(es));
         check_eq("hold_in_ready", 32'(sel ? in_ready_b : in_ready_a), 0);
      end
      in_valid_a = 1'b0; in_valid_b = 1'b0;
      check_eq("sum", 32'(sel ? sum_b : sum_a), 32'(es));
      check_eq("carry", 32'(sel ? carry_b : carry_a), 32'(ec));
      check_eq("overflow", 32'(sel ? overflow_b : overflow_a), 32'(eo));
      check_eq("busy_done", 32'(sel ? busy_b : busy_a), 1);
      if (sel) out_ready_b = 1'b1; else out_ready_a = 1'b1;
      tick;
      out_ready_a = 1'b0; out_ready_b = 1'b0;
      check_eq("release_valid", 32'(sel ? out_valid_b : out_valid_a), 0);
      check_eq("release_in_ready", 32'(sel ? in_ready_b : in_ready_a), 1);
      check_eq("release_busy", 32'(sel ? busy_b : busy_a), 0);
   endtask

   initial begin
      rst = 1'b1;
      in_valid_a = 1'b1; in_valid_b = 1'b1;
      out_ready_a = 1'b0; out_ready_b = 1'b0;
      num_1 = 16'h1234; num_2 = 16'h4321; c_in = 1'b0; sub_in = 1'b0;
      repeat (3) tick;
      check_eq("rst_out_valid", 32'(out_valid_a), 0);
      check_eq("rst_busy", 32'(busy_a), 0);
      check_eq("rst_sum", 32'(sum_a), 0);
      check_eq("rst_carry", 32'(carry_a), 0);
      check_eq("rst_overflow", 32'(overflow_a), 0);
      check_eq("rst_busy_c16", 32'(busy_b), 0);
      rst = 1'b0;
      in_valid_a = 1'b0; in_valid_b = 1'b0;
      check_eq("post_rst_in_ready", 32'(in_ready_a), 1);
      tick;
      check_eq("no_accept_in_rst", 32'(busy_a), 0);

      run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
      run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
      run_op(1'b0, 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
      run_op(1'b0, 16'h8000, 16'h0001, 1'b1, 1'b1, 2);
      run_op(1'b0, 16'h0F0F, 16'hF0F1, 1'b1, 1'b0, 10);

      // Abort an operation with a one-cycle reset in the middle of RUN.
      num_1 = 16'h5A5A; num_2 = 16'h1111; c_in = 1'b0; sub_in = 1'b0;
      in_valid_a = 1'b1;
      tick;
      in_valid_a = 1'b0;
      tick;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check_eq("abort_out_valid", 32'(out_valid_a), 0);
      check_eq("abort_sum", 32'(sum_a), 0);
      check_eq("abort_carry", 32'(carry_a), 0);
      check_eq("abort_overflow", 32'(overflow_a), 0);
      check_eq("abort_busy", 32'(busy_a), 0);
      check_eq("abort_in_ready", 32'(in_ready_a), 1);
      for (int i = 0; i < 6; i++) begin
         tick;
         check_eq("abort_stays_idle", 32'(out_valid_a), 0);
      end

      run_op(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 0);
      run_op(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, 1);

      for (int i = 0; i < 40; i++) begin
         run_op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)));
      end
      for (int i = 0; i < 15; i++) begin
         run_op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
